// File: rtl/bird_motion_ctl.sv
// Vertical-motion controller for the player sprite: gravity integration on a
// programmable physics tick, flap impulse, ceiling clamp, floor/collision game over.
module bird_motion_ctl #(
    parameter int CLK_DIV  = 4_000_000,
    parameter int YPOS_W   = 12,
    parameter int VEL_W    = 6,
    parameter int Y_MAX    = 767,
    parameter int Y_START  = 384,
    parameter int GRAVITY  = 1,
    parameter int VMAX     = 8,
    parameter int FLAP_VEL = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    flap,
    input  logic                    pause,
    input  logic                    collide,
    output logic [YPOS_W-1:0]       ypos,
    output logic signed [VEL_W-1:0] vel,
    output logic [1:0]              state_o,
    output logic                    endgame,
    output logic                    tick
);

    localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int SUM_W = YPOS_W + 2;
    localparam logic signed [SUM_W-1:0] Y_MAX_S  = SUM_W'(Y_MAX);
    localparam logic signed [SUM_W-1:0] ZERO_S   = '0;
    localparam logic signed [VEL_W-1:0] FLAP_V   = VEL_W'(-FLAP_VEL);
    localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        OVER  = 2'd3
    } state_t;

    state_t                    state;
    logic [CNT_W-1:0]          cnt;
    logic                      flap_pending;
    logic                      start_p1, flap_p1, pause_p1;
    logic                      start_edge, flap_edge, pause_edge;
    logic                      at_tick;
    logic signed [VEL_W-1:0]   v_next;
    logic signed [SUM_W-1:0]   y_next;
    logic                      floor_hit, ceil_hit;

    // Gravity step with terminal-velocity saturation.
    function automatic logic signed [VEL_W-1:0] fall_vel(input logic signed [VEL_W-1:0] v);
        logic signed [VEL_W+1:0] s;
        s = (VEL_W+2)'(v) + (VEL_W+2)'(GRAVITY);
        if (s > (VEL_W+2)'(VMAX))
            return VEL_W'(VMAX);
        return VEL_W'(s);
    endfunction

    // Clamp a candidate position into the playfield [0, Y_MAX].
    function automatic logic [YPOS_W-1:0] sat_ypos(input logic signed [SUM_W-1:0] y);
        if (y >= Y_MAX_S)
            return YPOS_W'(Y_MAX);
        if (y <= ZERO_S)
            return '0;
        return YPOS_W'(y);
    endfunction

    assign start_edge = start & ~start_p1;
    assign flap_edge  = flap  & ~flap_p1;
    assign pause_edge = pause & ~pause_p1;
    assign at_tick    = (cnt == CNT_LAST);

    assign v_next    = flap_pending ? FLAP_V : fall_vel(vel);
    assign y_next    = SUM_W'($signed({1'b0, ypos})) + SUM_W'(v_next);
    assign floor_hit = (y_next >= Y_MAX_S);
    assign ceil_hit  = (y_next <= ZERO_S);

    assign state_o = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            flap_pending <= 1'b0;
            start_p1     <= 1'b0;
            flap_p1      <= 1'b0;
            pause_p1     <= 1'b0;
            ypos         <= YPOS_W'(Y_START);
            vel          <= '0;
            endgame      <= 1'b0;
            tick         <= 1'b0;
        end else begin
            start_p1 <= start;
            flap_p1  <= flap;
            pause_p1 <= pause;
            tick     <= 1'b0;
            case (state)
                IDLE: begin
                    ypos         <= YPOS_W'(Y_START);
                    vel          <= '0;
                    endgame      <= 1'b0;
                    flap_pending <= 1'b0;
                    if (start_edge) begin
                        state <= RUN;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    if (collide) begin
                        state        <= OVER;
                        endgame      <= 1'b1;
                        flap_pending <= 1'b0;
                    end else begin
                        if (at_tick) begin
                            // A flap edge on the tick cycle is kept for the next tick.
                            tick         <= 1'b1;
                            cnt          <= '0;
                            flap_pending <= flap_edge;
                            ypos         <= sat_ypos(y_next);
                            vel          <= (floor_hit || ceil_hit) ? '0 : v_next;
                        end else begin
                            cnt <= cnt + 1'b1;
                            if (flap_edge)
                                flap_pending <= 1'b1;
                        end
                        if (at_tick && floor_hit) begin
                            state   <= OVER;
                            endgame <= 1'b1;
                        end else if (pause_edge) begin
                            state <= PAUSE;
                        end
                    end
                end
                PAUSE: begin
                    flap_pending <= 1'b0;
                    if (start_edge) begin
                        state <= IDLE;
                        ypos  <= YPOS_W'(Y_START);
                        vel   <= '0;
                    end else if (pause_edge) begin
                        state <= RUN;
                    end
                end
                OVER: begin
                    flap_pending <= 1'b0;
                    if (start_edge) begin
                        state   <= IDLE;
                        ypos    <= YPOS_W'(Y_START);
                        vel     <= '0;
                        endgame <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bird_motion_ctl.sv
// Directed bench for bird_motion_ctl with a per-cycle behavioural model.
module tb_bird_motion_ctl;

    localparam int CLK_DIV = 4, YPOS_W = 12, VEL_W = 6, Y_MAX = 100, Y_START = 50;
    localparam int GRAVITY = 1, VMAX = 4, FLAP_VEL = 3;

    logic clk = 1'b0, rst = 1'b1;
    logic start = 1'b0, flap = 1'b0, pause = 1'b0, collide = 1'b0;
    logic [YPOS_W-1:0]       ypos;
    logic signed [VEL_W-1:0] vel;
    logic [1:0]              state_o;
    logic                    endgame, tick;

    int nvec = 0, nerr = 0;
    bit cmp_en = 1'b0;

    // Behavioural model state (game phase: 0 idle, 1 run, 2 pause, 3 over).
    int m_st = 0, m_y = Y_START, m_v = 0, m_cnt = 0;
    bit m_pend = 0, m_tick = 0, m_ps = 0, m_pf = 0, m_pp = 0;

    bird_motion_ctl #(
        .CLK_DIV(CLK_DIV), .YPOS_W(YPOS_W), .VEL_W(VEL_W), .Y_MAX(Y_MAX),
        .Y_START(Y_START), .GRAVITY(GRAVITY), .VMAX(VMAX), .FLAP_VEL(FLAP_VEL)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .flap(flap), .pause(pause),
        .collide(collide), .ypos(ypos), .vel(vel), .state_o(state_o),
        .endgame(endgame), .tick(tick)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        bit se, fe, pe;
        int nv, ny;
        se = start && !m_ps;
        fe = flap && !m_pf;
        pe = pause && !m_pp;
        m_ps = start; m_pf = flap; m_pp = pause;
        m_tick = 0;
        if (rst) begin
            m_st = 0; m_y = Y_START; m_v = 0; m_cnt = 0; m_pend = 0;
            m_ps = 0; m_pf = 0; m_pp = 0;
        end else if (m_st == 0) begin
            m_y = Y_START; m_v = 0; m_pend = 0;
            if (se) begin m_st = 1; m_cnt = 0; end
        end else if (m_st == 1) begin
            if (collide) begin
                m_st = 3;
            end else begin
                if (m_cnt == CLK_DIV - 1) begin
                    m_tick = 1; m_cnt = 0;
                    nv = m_pend ? -FLAP_VEL : ((m_v + GRAVITY > VMAX) ? VMAX : m_v + GRAVITY);
                    m_pend = fe;
                    ny = m_y + nv;
                    if (ny >= Y_MAX) begin m_y = Y_MAX; m_v = 0; m_st = 3; end
                    else if (ny <= 0) begin m_y = 0; m_v = 0; end
                    else begin m_y = ny; m_v = nv; end
                end else begin
                    m_cnt++;
                    if (fe) m_pend = 1;
                end
                if (m_st == 1 && pe) m_st = 2;
            end
        end else if (m_st == 2) begin
            m_pend = 0;
            if (se) begin m_st = 0; m_y = Y_START; m_v = 0; end
            else if (pe) m_st = 1;
        end else begin
            m_pend = 0;
            if (se) begin m_st = 0; m_y = Y_START; m_v = 0; end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            nvec++;
            if (int'(ypos) != m_y || int'(vel) != m_v || int'(state_o) != m_st ||
                endgame != (m_st == 3) || tick != m_tick) begin
                nerr++;
                $display("FAIL model t=%0t: got y=%0d v=%0d st=%0d eg=%0b tk=%0b want y=%0d v=%0d st=%0d eg=%0b tk=%0b",
                         $time, ypos, vel, state_o, endgame, tick, m_y, m_v, m_st, (m_st == 3), m_tick);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (tick !== 1'b1 && n < 50);
        if (tick !== 1'b1) begin
            nvec++; nerr++;
            $display("FAIL tick_timeout: got no tick after %0d cycles expected one", n);
        end
    endtask

    task automatic pulse_start; start = 1'b1; cyc(1); start = 1'b0; endtask
    task automatic pulse_flap;  flap  = 1'b1; cyc(1); flap  = 1'b0; endtask
    task automatic pulse_pause; pause = 1'b1; cyc(1); pause = 1'b0; endtask

    initial begin
        int n;
        int ff_y[13] = '{51, 53, 56, 60, 64, 68, 72, 76, 80, 84, 88, 92, 96};
        int ff_v[13] = '{1, 2, 3, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4};

        // Reset state
        cyc(2); cmp_en = 1'b1; rst = 1'b0;
        chk("rst_ypos", int'(ypos), 50);
        chk("rst_vel", int'(vel), 0);
        chk("rst_state", int'(state_o), 0);
        chk("rst_endgame", int'(endgame), 0);
        chk("rst_tick", int'(tick), 0);

        // Free fall to the floor
        pulse_start;
        chk("ff_state", int'(state_o), 1);
        for (int k = 0; k < 13; k++) begin
            wait_tick(n);
            chk("ff_interval", n, 4);
            chk("ff_vel", int'(vel), ff_v[k]);
            chk("ff_ypos", int'(ypos), ff_y[k]);
        end
        wait_tick(n);
        chk("floor_ypos", int'(ypos), 100);
        chk("floor_vel", int'(vel), 0);
        chk("floor_state", int'(state_o), 3);
        chk("floor_endgame", int'(endgame), 1);
        pulse_start;
        chk("over_idle_state", int'(state_o), 0);
        chk("over_idle_ypos", int'(ypos), 50);
        chk("over_idle_endgame", int'(endgame), 0);
        cyc(1);

        // Flap impulse
        pulse_start;
        repeat (3) wait_tick(n);
        chk("pre_flap_ypos", int'(ypos), 56);
        pulse_flap;
        wait_tick(n);
        chk("flap_interval", n, 3);
        chk("flap_vel", int'(vel), -3);
        chk("flap_ypos", int'(ypos), 53);
        wait_tick(n);
        chk("after_flap_vel", int'(vel), -2);
        chk("after_flap_ypos", int'(ypos), 51);

        // Collide on the tick cycle
        cyc(3); collide = 1'b1; cyc(1); collide = 1'b0;
        chk("col_state", int'(state_o), 3);
        chk("col_ypos", int'(ypos), 51);
        chk("col_vel", int'(vel), -2);
        chk("col_tick", int'(tick), 0);
        chk("col_endgame", int'(endgame), 1);
        pulse_start;
        chk("col_idle_ypos", int'(ypos), 50);
        chk("col_idle_state", int'(state_o), 0);
        cyc(1);
        pulse_start;
        chk("restart_state", int'(state_o), 1);

        // Ceiling clamp
        for (int k = 1; k <= 17; k++) begin
            pulse_flap;
            wait_tick(n);
            chk("ceil_ypos", int'(ypos), (50 - 3 * k > 0) ? 50 - 3 * k : 0);
        end
        chk("ceil_vel", int'(vel), 0);
        chk("ceil_state", int'(state_o), 1);

        // Pause mid-interval
        wait_tick(n);
        chk("post_ceil_ypos", int'(ypos), 1);
        cyc(1);
        pulse_pause;
        chk("pause_state", int'(state_o), 2);
        for (int i = 0; i < 20; i++) begin
            flap = i[0];
            cyc(1);
            chk("pause_ypos", int'(ypos), 1);
            chk("pause_vel", int'(vel), 1);
        end
        flap = 1'b0;
        pulse_pause;
        chk("resume_state", int'(state_o), 1);
        wait_tick(n);
        chk("resume_interval", n, 2);
        chk("resume_vel", int'(vel), 2);
        chk("resume_ypos", int'(ypos), 3);

        // Flap edge on the tick cycle is deferred
        cyc(3); flap = 1'b1; cyc(1); flap = 1'b0;
        chk("flap_tick_tick", int'(tick), 1);
        chk("flap_tick_vel", int'(vel), 3);
        chk("flap_tick_ypos", int'(ypos), 6);
        wait_tick(n);
        chk("deferred_interval", n, 4);
        chk("deferred_vel", int'(vel), -3);
        chk("deferred_ypos", int'(ypos), 3);

        // Pause on a tick, then reset mid-run
        rst = 1'b1; cyc(2); rst = 1'b0;
        pulse_start;
        repeat (3) wait_tick(n);
        cyc(3); pause = 1'b1; cyc(1); pause = 1'b0;
        chk("tick_pause_state", int'(state_o), 2);
        chk("tick_pause_ypos", int'(ypos), 60);
        chk("tick_pause_tick", int'(tick), 1);
        pulse_pause;
        chk("run_ypos", int'(ypos), 60);
        rst = 1'b1; cyc(1);
        chk("midrst_ypos", int'(ypos), 50);
        chk("midrst_vel", int'(vel), 0);
        chk("midrst_state", int'(state_o), 0);
        chk("midrst_endgame", int'(endgame), 0);
        chk("midrst_tick", int'(tick), 0);
        rst = 1'b0;
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/bird_motion_ctl.md
# bird_motion_ctl

Parametrised vertical-motion controller for the player sprite, replacing the fixed-step up/down controller. It integrates a signed velocity under gravity on a programmable physics tick, applies a flap impulse, and clamps at the ceiling. It ends the game on a floor hit or an external collision, and supports pause and restart. It sits between the button synchroniser and the sprite-drawing logic and feeds `ypos`/`endgame` to the renderer.

## Interface
- `CLK_DIV`, 4_000_000: clock cycles per physics tick (≥2)
- `YPOS_W`, 12: width of `ypos`
- `VEL_W`, 6: width of signed `vel`
- `Y_MAX`, 767: floor coordinate (VER_PIXELS-1)
- `Y_START`, 384: spawn coordinate
- `GRAVITY`, 1: velocity increment per tick
- `VMAX`, 8: terminal fall velocity
- `FLAP_VEL`, 6: upward velocity magnitude set by a flap

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  level; rising edge starts or restarts a game
- `flap`  in  1  level; rising edge requests an impulse
- `pause`  in  1  level; rising edge toggles RUN/PAUSE
- `collide`  in  1  level; obstacle hit from the collision checker
- `ypos`  out  YPOS_W  sprite top coordinate, registered
- `vel`  out  VEL_W signed  current velocity, positive = down, registered
- `state_o`  out  2  IDLE=0, RUN=1, PAUSE=2, OVER=3
- `endgame`  out  1  high while in OVER, registered
- `tick`  out  1  one-cycle pulse on each applied physics tick

## Operation
- Edge detect: register the previous level of `start`, `flap` and `pause`. An edge is `in & ~prev`. Previous-level registers reset to 0.
- Reset values: state IDLE, `ypos`=Y_START, `vel`=0, `endgame`=0, `tick`=0, tick counter 0, flap_pending 0.
- **IDLE**
  - `ypos`=Y_START, `vel`=0.
  - Start edge → RUN, tick counter cleared.
  - All other inputs ignored.
- **RUN**
  - Tick counter counts 0..CLK_DIV-1 and wraps. `tick` fires when the counter equals CLK_DIV-1.
  - Flap edge sets flap_pending.
  - On a tick:
    - If flap_pending: v' = -FLAP_VEL and flap_pending clears.
    - Otherwise: v' = min(vel+GRAVITY, VMAX).
    - Then y' = ypos + v', computed signed in YPOS_W+2 bits.
    - If y' ≥ Y_MAX: `ypos`=Y_MAX, `vel`=0, go to OVER.
    - Else if y' ≤ 0: `ypos`=0, `vel`=0 (ceiling clamp, no game over).
    - Else: `ypos`=y', `vel`=v'.
  - `collide`=1 → OVER. `ypos` and `vel` hold, and any tick that cycle is discarded (`tick` stays 0).
  - Pause edge → PAUSE. A tick in the same cycle is applied first.
  - Start edge ignored.
- **PAUSE**
  - Counter, `ypos` and `vel` frozen. flap_pending cleared. Flap and collide ignored.
  - Pause edge → RUN, counter resumes from its frozen value.
  - Start edge → IDLE.
- **OVER**
  - `endgame`=1, `ypos` and `vel` hold.
  - Start edge → IDLE (Y_START, `vel` 0). The next start edge begins a new game.
- Priority within one cycle in RUN: collide > tick > pause.

## Timing
- All outputs are registered. An input sampled high at edge k (low at k-1) takes effect in state/outputs after edge k.
- First tick occurs CLK_DIV cycles after entering RUN.
- `tick` high for exactly one cycle, coincident with the updated `ypos`/`vel`.
- A flap edge arriving in the same cycle as a tick is latched and applied on the following tick.
- `endgame` rises the cycle after `state_o` changes to OVER? No: `endgame` and `state_o` change on the same edge.
- `rst` mid-operation restores reset values on the next edge, regardless of state.

## Test plan
Parameters for all scenarios: CLK_DIV=4, Y_MAX=100, Y_START=50, GRAVITY=1, VMAX=4, FLAP_VEL=3.
- Free fall: start pulse, no other input → `tick` every 4 cycles. `vel` 1,2,3,4,4,… and `ypos` 51,53,56,60,64,68,…,96. The next tick gives y'=100, so `ypos`=100, `endgame`=1, `state_o`=3.
- Flap: after `ypos`=56 (`vel`=3), flap pulse → next tick `vel`=-3, `ypos`=53. Following tick `vel`=-2, `ypos`=51.
- Ceiling: flap before every tick from Y_START → `ypos` decreases by 3 per tick. The tick producing y' ≤ 0 gives `ypos`=0, `vel`=0, with state still RUN.
- Pause: pause edge mid-interval → `ypos`, `vel` and counter frozen for 20 cycles, flaps ignored. A second pause edge resumes and the next tick arrives after the remaining counter cycles.
- Collide and simultaneous events: `collide`=1 in the same cycle as a tick → OVER, `ypos` unchanged, `tick`=0. Start edge → IDLE with `ypos`=50, then start → RUN.
- Reset mid-run: `rst`=1 in RUN with `ypos`=60 → next cycle `ypos`=50, `vel`=0, `state_o`=0, `endgame`=0, `tick`=0.
